ex_mem_stage: RTL and testbench

//  Execute->Memory pipeline boundary directly downstream of the ALU. Captures the ALU result, the NZVC flags
//  and the instruction's writeback/memory controls. Decouples the two stages with a valid/ready handshake

---
 rtl/ex_mem_pkg.sv | 23 ++
 rtl/skid_buffer.sv | 88 ++++++++
 rtl/ex_mem_stage.sv | 106 ++++++++++
 tb/tb_ex_mem_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types for the EX->MEM pipeline boundary: payload struct, flag bit indices, flag vector type.
package ex_mem_pkg;

  localparam int DATA_W = 16;
  localparam int RD_W   = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef logic [3:0] flags_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic              reg_we;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] store;
  } ex_mem_payload_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer: MAIN drives the outputs, SKID catches one beat under backpressure.
// in_ready depends only on registered state, so there is no combinational path from out_ready.
module skid_buffer #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data,
  output logic accept
);

  logic main_valid, skid_valid;
  logic main_valid_d, skid_valid_d;
  logic load_main_in, load_main_skid, load_skid;
  logic drain;
  T     main_data, skid_data;

  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready & ~flush;
  assign drain     = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  // NOTE: every signal gets a default before any branch, otherwise a missed path infers a latch.
  always_comb begin
    main_valid_d   = main_valid;
    skid_valid_d   = skid_valid;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid) begin
      // in_ready is low here, so only a drain can happen: promote SKID into MAIN.
      if (drain) begin
        load_main_skid = 1'b1;
        skid_valid_d   = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid || drain) begin
        load_main_in = 1'b1;
        main_valid_d = 1'b1;
      end else begin
        load_skid    = 1'b1;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      main_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_valid <= main_valid_d;
      skid_valid <= skid_valid_d;
    end
  end

  // NOTE: payload registers are reset too because the outputs must read zero after reset;
  // flush only clears the valids and leaves the data stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: skid-buffered payload plus the architectural NZVC flag register.
// Optional stall counter on out_valid & ~out_ready when EX_MEM_STALL_CNT_EN is defined.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_result,
  input  logic [3:0]            in_flags,
  input  logic                  in_flags_we,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_we,
  input  logic                  in_mem_we,
  input  logic                  in_mem_re,
  input  logic [WIDTH-1:0]      in_store,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_we,
  output logic                  out_mem_we,
  output logic                  out_mem_re,
  output logic [WIDTH-1:0]      out_store,
  output logic [3:0]            flags_q
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  // Same layout as ex_mem_payload_t, but sized from this instance's parameters.
  typedef struct packed {
    logic [WIDTH-1:0]      result;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_we;
    logic                  mem_we;
    logic                  mem_re;
    logic [WIDTH-1:0]      store;
  } payload_t;

  payload_t in_payload, out_payload;
  logic     accept;
  flags_t   flags_r;

  assign in_payload = '{
    result: in_result,
    rd:     in_rd,
    reg_we: in_reg_we,
    mem_we: in_mem_we,
    mem_re: in_mem_re,
    store:  in_store
  };

  skid_buffer #(.T(payload_t)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload),
    .accept    (accept)
  );

  assign out_result = out_payload.result;
  assign out_rd     = out_payload.rd;
  assign out_reg_we = out_payload.reg_we;
  assign out_mem_we = out_payload.mem_we;
  assign out_mem_re = out_payload.mem_re;
  assign out_store  = out_payload.store;

  // Flags commit when the instruction is accepted, so branches see them without waiting for drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= '0;
    end else if (accept && in_flags_we) begin
      flags_r <= in_flags;
    end
  end

  assign flags_q = flags_r;

`ifdef EX_MEM_STALL_CNT_EN
  logic [15:0] stall_r;

  // Saturating; flush deliberately leaves the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_r <= '0;
    end else if (out_valid && !out_ready && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'd1;
    end
  end

  assign stall_cnt = stall_r;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: queue-based reference model compared every negedge,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ex_mem_stage;
  import ex_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [3:0]  in_flags;
  logic        in_flags_we;
  logic [3:0]  in_rd;
  logic        in_reg_we;
  logic        in_mem_we;
  logic        in_mem_re;
  logic [15:0] in_store;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_rd;
  logic        out_reg_we;
  logic        out_mem_we;
  logic        out_mem_re;
  logic [15:0] out_store;
  logic [3:0]  flags_q;
`ifdef EX_MEM_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  ex_mem_stage #(.WIDTH(16), .REG_ADDR_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_flags    (in_flags),
    .in_flags_we (in_flags_we),
    .in_rd       (in_rd),
    .in_reg_we   (in_reg_we),
    .in_mem_we   (in_mem_we),
    .in_mem_re   (in_mem_re),
    .in_store    (in_store),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_reg_we  (out_reg_we),
    .out_mem_we  (out_mem_we),
    .out_mem_re  (out_mem_re),
    .out_store   (out_store),
    .flags_q     (flags_q)
`ifdef EX_MEM_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: an in-order FIFO of at most two accepted entries.
  ex_mem_payload_t m_q[$];
  logic [3:0]      m_flags;
  int              m_stall;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_flags = 4'b0000;
      m_stall = 0;
    end else begin
      automatic bit acc = in_valid && (m_q.size() < 2) && !flush;
      automatic bit drn = (m_q.size() > 0) && out_ready;
      if (m_q.size() > 0 && !out_ready && m_stall < 16'hFFFF) m_stall++;
      if (flush) begin
        m_q.delete();
      end else begin
        if (drn) void'(m_q.pop_front());
        if (acc) m_q.push_back('{in_result, in_rd, in_reg_we, in_mem_we, in_mem_re, in_store});
      end
      if (acc && in_flags_we) m_flags = in_flags;
    end
  end

  always @(negedge clk) begin
    check("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
    check("in_ready", {31'd0, in_ready}, {31'd0, m_q.size() < 2});
    check("flags_q", {28'd0, flags_q}, {28'd0, m_flags});
    if (m_q.size() > 0) begin
      check("out_result", {16'd0, out_result}, {16'd0, m_q[0].result});
      check("out_rd", {28'd0, out_rd}, {28'd0, m_q[0].rd});
      check("out_ctl", {29'd0, out_reg_we, out_mem_we, out_mem_re},
            {29'd0, m_q[0].reg_we, m_q[0].mem_we, m_q[0].mem_re});
      check("out_store", {16'd0, out_store}, {16'd0, m_q[0].store});
    end
`ifdef EX_MEM_STALL_CNT_EN
    check("stall_cnt", {16'd0, stall_cnt}, m_stall);
`endif
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [15:0] res, input logic [3:0] fl, input logic fwe);
    in_valid    = v;
    in_result   = res;
    in_flags    = fl;
    in_flags_we = fwe;
    in_rd       = 4'($urandom);
    in_reg_we   = 1'($urandom);
    in_mem_we   = 1'($urandom);
    in_mem_re   = 1'($urandom);
    in_store    = 16'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 16'h0, 4'h0, 1'b0);
    cycle();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", {16'd0, out_result}, 32'd0);
    rst_n = 1'b1;
    cycle();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Stream: one-cycle latency, no backpressure.
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      set_in(1'b1, 16'(i), 4'h0, 1'b0);
      cycle();
      check("stream_result", {16'd0, out_result}, i);
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    cycle();
    check("stream_empty", {31'd0, out_valid}, 32'd0);

    // Backpressure fills MAIN then SKID.
    out_ready = 1'b0;
    set_in(1'b1, 16'h00AA, 4'h0, 1'b0);
    cycle();
    set_in(1'b1, 16'h00BB, 4'h0, 1'b0);
    cycle();
    in_valid = 1'b0;
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_hold_aa", {16'd0, out_result}, 32'h00AA);
    cycle();
    check("bp_still_aa", {16'd0, out_result}, 32'h00AA);
    out_ready = 1'b1;
    cycle();
    check("bp_bb", {16'd0, out_result}, 32'h00BB);
    check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    cycle();
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Flags commit on accept only when in_flags_we.
    set_in(1'b1, 16'h0010, 4'b0100, 1'b1);
    cycle();
    check("flags_0100", {28'd0, flags_q}, 32'h4);
    check("flags_z_bit", {31'd0, flags_q[FLAG_Z]}, 32'd1);
    set_in(1'b1, 16'h0011, 4'b1001, 1'b0);
    cycle();
    check("flags_we0_hold", {28'd0, flags_q}, 32'h4);
    out_ready = 1'b0;
    set_in(1'b1, 16'h0012, 4'b0000, 1'b0);
    cycle();
    check("flags_full", {31'd0, in_ready}, 32'd0);
    set_in(1'b1, 16'h0013, 4'b1111, 1'b1);
    cycle();
    check("flags_stalled_hold", {28'd0, flags_q}, 32'h4);

    // Flush with both entries full and a flag-writing input pending.
    flush = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_flags", {28'd0, flags_q}, 32'h4);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 16'($urandom), 4'($urandom), 1'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      cycle();
    end

    // Reset mid-traffic: outputs clear asynchronously.
    out_ready = 1'b0;
    flush     = 1'b0;
    set_in(1'b1, 16'h1234, 4'b1010, 1'b1);
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_flags", {28'd0, flags_q}, 32'd0);
    in_valid = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef EX_MEM_STALL_CNT_EN
    do_reset();
    out_ready = 1'b0;
    set_in(1'b1, 16'h0055, 4'h0, 1'b0);
    cycle();
    in_valid = 1'b0;
    repeat (10) cycle();
    check("stall_10", {16'd0, stall_cnt}, 32'd10);
    out_ready = 1'b1;
    flush     = 1'b1;
    cycle();
    flush = 1'b0;
    check("stall_after_flush", {16'd0, stall_cnt}, 32'd10);
    cycle();
`else
    do_reset();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
